// File: rtl/video_memory_assign.sv
// VGA text-mode address/colour generator: maps pixel coordinates to character-memory and font-ROM
// addresses and selects the pixel colour. Define VMA_HEADER_EN to enable the prompt-header path.
module video_memory_assign #(
  parameter int unsigned                BASH_HEAD_LEN = 9,
  parameter logic [8*BASH_HEAD_LEN-1:0] HEAD_STR      = "MYS@bash$"
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  h_addr,
  input  logic [9:0]  v_addr,
  input  logic [12:0] roll_cnt,
  input  logic [7:0]  char_code,
  input  logic [11:0] line,
  input  logic [11:0] line_header,
  input  logic [7:0]  scanCode_E0,
  input  logic [23:0] color_background,
  input  logic [23:0] color_text,
  output logic [7:0]  keysX,
  output logic [7:0]  keysY,
  output logic [12:0] keys_index,
  output logic [7:0]  offsetX,
  output logic [7:0]  offsetY,
  output logic [11:0] vm_index,
  output logic [11:0] vm_index_header,
  output logic [23:0] showcolor,
  output logic [23:0] showcolor_header,
  output logic        direction_flag
);

  localparam int unsigned CELL_W     = 9;
  localparam int unsigned ROW_CHARS  = 70;
  localparam int unsigned RIGHT_EDGE = 630;
  localparam int unsigned COLOR_W    = 24;

  logic [3:0]         offset_x_q;
  logic               margin_q;
  logic [COLOR_W-1:0] bg_q;
  logic [COLOR_W-1:0] txt_q;
  logic               direction_flag_q;
  logic               direction_flag_d;

  logic [7:0]  head_char;
  logic        head_hit;
  logic [11:0] vm_hdr;
  logic [15:0] line_ext;

  // Cell coordinates and in-cell offsets
  assign keysX      = 8'(h_addr / 10'(CELL_W));
  assign keysY      = 8'(v_addr >> 4);
  assign offsetX    = 8'(h_addr - 10'(10'(keysX) * 10'(CELL_W)));
  assign offsetY    = {4'b0000, v_addr[3:0]};
  assign keys_index = 13'(13'(keysY) * 13'(ROW_CHARS)) + 13'(keysX) + roll_cnt;
  assign vm_index   = {char_code, 4'b0000} + 12'(offsetY);

  // Prompt character lookup; byte 0 of HEAD_STR sits in the most significant byte
  always_comb begin
    head_char = 8'h00;
    head_hit  = 1'b0;
    for (int unsigned k = 0; k < BASH_HEAD_LEN; k++) begin
      if (32'(keysX) == k) begin
        head_hit  = 1'b1;
        head_char = HEAD_STR[8*(BASH_HEAD_LEN-1-k) +: 8];
      end
    end
  end

  assign vm_hdr = head_hit ? ({head_char, 4'b0000} + 12'(offsetY)) : 12'h000;

  assign direction_flag_d = (scanCode_E0 == 8'h75) || (scanCode_E0 == 8'h72) ||
                            (scanCode_E0 == 8'h6B) || (scanCode_E0 == 8'h74);

  // Stage-2 registers line up with the one-cycle font-ROM latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      offset_x_q       <= 4'h0;
      margin_q         <= 1'b0;
      bg_q             <= '0;
      txt_q            <= '0;
      direction_flag_q <= 1'b0;
    end else begin
      offset_x_q       <= offsetX[3:0];
      margin_q         <= (h_addr >= 10'(RIGHT_EDGE));
      bg_q             <= color_background;
      txt_q            <= color_text;
      direction_flag_q <= direction_flag_d;
    end
  end

  assign direction_flag = direction_flag_q;
  assign line_ext       = {4'h0, line};
  assign showcolor      = (!margin_q && line_ext[offset_x_q]) ? txt_q : bg_q;

`ifdef VMA_HEADER_EN
  logic [15:0] line_header_ext;

  assign line_header_ext  = {4'h0, line_header};
  assign vm_index_header  = vm_hdr;
  assign showcolor_header = (!margin_q && line_header_ext[offset_x_q]) ? txt_q : bg_q;
`else
  logic unused_hdr;

  assign unused_hdr       = ^{line_header, vm_hdr};
  assign vm_index_header  = vm_index;
  assign showcolor_header = showcolor;
`endif

endmodule

// File: tb/tb_video_memory_assign.sv
// Directed self-checking bench for video_memory_assign.
`timescale 1ns/1ps
module tb_video_memory_assign;

  logic        clk;
  logic        rst_n;
  logic [9:0]  h_addr;
  logic [9:0]  v_addr;
  logic [12:0] roll_cnt;
  logic [7:0]  char_code;
  logic [11:0] line;
  logic [11:0] line_header;
  logic [7:0]  scanCode_E0;
  logic [23:0] color_background;
  logic [23:0] color_text;
  logic [7:0]  keysX;
  logic [7:0]  keysY;
  logic [12:0] keys_index;
  logic [7:0]  offsetX;
  logic [7:0]  offsetY;
  logic [11:0] vm_index;
  logic [11:0] vm_index_header;
  logic [23:0] showcolor;
  logic [23:0] showcolor_header;
  logic        direction_flag;

  int checks;
  int errors;

  video_memory_assign dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .h_addr           (h_addr),
    .v_addr           (v_addr),
    .roll_cnt         (roll_cnt),
    .char_code        (char_code),
    .line             (line),
    .line_header      (line_header),
    .scanCode_E0      (scanCode_E0),
    .color_background (color_background),
    .color_text       (color_text),
    .keysX            (keysX),
    .keysY            (keysY),
    .keys_index       (keys_index),
    .offsetX          (offsetX),
    .offsetY          (offsetY),
    .vm_index         (vm_index),
    .vm_index_header  (vm_index_header),
    .showcolor        (showcolor),
    .showcolor_header (showcolor_header),
    .direction_flag   (direction_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; h_addr = 10'd20; v_addr = 10'd35; roll_cnt = 13'd0;
    char_code = 8'h41; line = 12'hFFF; line_header = 12'hFFF; scanCode_E0 = 8'h75;
    color_background = 24'h112233; color_text = 24'h445566;
    @(posedge clk); #1;
    checks++; if (direction_flag !== 1'b0) begin errors++;
      $display("FAIL reset_dir actual=%0h required=0", direction_flag); end
    checks++; if (showcolor !== 24'h0) begin errors++;
      $display("FAIL reset_showcolor actual=%06h required=000000", showcolor); end
    checks++; if (showcolor_header !== 24'h0) begin errors++;
      $display("FAIL reset_showcolor_hdr actual=%06h required=000000", showcolor_header); end
    scanCode_E0 = 8'h00;
    rst_n = 1'b1;
  endtask

  task automatic check_addr(input logic [9:0] h, input logic [9:0] v, input logic [12:0] r,
                            input logic [7:0] cc, input logic [7:0] ex_kx, input logic [7:0] ex_ky,
                            input logic [7:0] ex_ox, input logic [7:0] ex_oy,
                            input logic [12:0] ex_ki, input logic [11:0] ex_vm);
    h_addr = h; v_addr = v; roll_cnt = r; char_code = cc;
    #1;
    checks++; if (keysX !== ex_kx) begin errors++;
      $display("FAIL keysX h=%0d actual=%0d required=%0d", h, keysX, ex_kx); end
    checks++; if (keysY !== ex_ky) begin errors++;
      $display("FAIL keysY v=%0d actual=%0d required=%0d", v, keysY, ex_ky); end
    checks++; if (offsetX !== ex_ox) begin errors++;
      $display("FAIL offsetX h=%0d actual=%0d required=%0d", h, offsetX, ex_ox); end
    checks++; if (offsetY !== ex_oy) begin errors++;
      $display("FAIL offsetY v=%0d actual=%0d required=%0d", v, offsetY, ex_oy); end
    checks++; if (keys_index !== ex_ki) begin errors++;
      $display("FAIL keys_index h=%0d v=%0d r=%0d actual=%0d required=%0d", h, v, r, keys_index, ex_ki); end
    checks++; if (vm_index !== ex_vm) begin errors++;
      $display("FAIL vm_index cc=%02h actual=%03h required=%03h", cc, vm_index, ex_vm); end
  endtask

  task automatic test_address();
    check_addr(10'd20,   10'd35,   13'd0,    8'h00, 8'd2,   8'd2,  8'd2, 8'd3,  13'd142,  12'h003);
    check_addr(10'd20,   10'd35,   13'd70,   8'h41, 8'd2,   8'd2,  8'd2, 8'd3,  13'd212,  12'h413);
    check_addr(10'd635,  10'd479,  13'd0,    8'h20, 8'd70,  8'd29, 8'd5, 8'd15, 13'd2100, 12'h20F);
    check_addr(10'd20,   10'd35,   13'd8191, 8'h00, 8'd2,   8'd2,  8'd2, 8'd3,  13'd141,  12'h003);
    check_addr(10'd1023, 10'd1023, 13'd0,    8'hFF, 8'd113, 8'd63, 8'd6, 8'd15, 13'd4523, 12'hFFF);
    check_addr(10'd8,    10'd16,   13'd0,    8'h01, 8'd0,   8'd1,  8'd8, 8'd0,  13'd70,   12'h010);
  endtask

  // Captures inputs on a clock, then scrambles the live inputs so only delayed values matter
  task automatic check_color(input logic [9:0] h, input logic [23:0] txt, input logic [23:0] bg,
                             input logic [11:0] ln, input logic [23:0] ex, input string name);
    h_addr = h; color_text = txt; color_background = bg;
    @(posedge clk); #1;
    h_addr = 10'd4; color_text = 24'hDEAD01; color_background = 24'hBEEF02;
    line = ln; line_header = ln;
    #1;
    checks++; if (showcolor !== ex) begin errors++;
      $display("FAIL %s actual=%06h required=%06h", name, showcolor, ex); end
`ifndef VMA_HEADER_EN
    checks++; if (showcolor_header !== ex) begin errors++;
      $display("FAIL %s_hdr actual=%06h required=%06h", name, showcolor_header, ex); end
`endif
  endtask

  task automatic test_color();
    check_color(10'd20, 24'hFFFFFF, 24'h000000, 12'h004, 24'hFFFFFF, "color_bit_set");
    check_color(10'd20, 24'hFFFFFF, 24'h000000, 12'h000, 24'h000000, "color_bit_clear");
    check_color(10'd0,  24'h123456, 24'hABCDEF, 12'h001, 24'h123456, "color_off0_set");
    check_color(10'd0,  24'h123456, 24'hABCDEF, 12'hFFE, 24'hABCDEF, "color_off0_clear");
    check_color(10'd8,  24'h0F0F0F, 24'hF0F0F0, 12'h100, 24'h0F0F0F, "color_off8_set");
    check_color(10'd17, 24'h0F0F0F, 24'hF0F0F0, 12'h0FF, 24'hF0F0F0, "color_off8_clear");
  endtask

  task automatic test_margin();
    check_color(10'd635, 24'hFFFFFF, 24'h00FF00, 12'hFFF, 24'h00FF00, "margin_635");
    check_color(10'd630, 24'hFFFFFF, 24'h00FF00, 12'hFFF, 24'h00FF00, "margin_630");
    check_color(10'd629, 24'hFFFFFF, 24'h00FF00, 12'hFFF, 24'hFFFFFF, "margin_629");
  endtask

  task automatic test_header();
`ifdef VMA_HEADER_EN
    h_addr = 10'd0; v_addr = 10'd3; #1;
    checks++; if (vm_index_header !== 12'h4D3) begin errors++;
      $display("FAIL hdr_M actual=%03h required=4D3", vm_index_header); end
    h_addr = 10'd72; v_addr = 10'd5; #1;
    checks++; if (vm_index_header !== 12'h245) begin errors++;
      $display("FAIL hdr_dollar actual=%03h required=245", vm_index_header); end
    h_addr = 10'd81; #1;
    checks++; if (vm_index_header !== 12'h000) begin errors++;
      $display("FAIL hdr_past actual=%03h required=000", vm_index_header); end
`else
    h_addr = 10'd0; v_addr = 10'd3; char_code = 8'h62; #1;
    checks++; if (vm_index_header !== 12'h623) begin errors++;
      $display("FAIL hdr_alias actual=%03h required=623", vm_index_header); end
    h_addr = 10'd81; v_addr = 10'd9; char_code = 8'h7E; #1;
    checks++; if (vm_index_header !== 12'h7E9) begin errors++;
      $display("FAIL hdr_alias_far actual=%03h required=7E9", vm_index_header); end
`endif
  endtask

  task automatic check_dir(input logic [7:0] sc, input logic ex);
    scanCode_E0 = sc;
    @(posedge clk); #1;
    scanCode_E0 = 8'h00;
    checks++; if (direction_flag !== ex) begin errors++;
      $display("FAIL dir sc=%02h actual=%0b required=%0b", sc, direction_flag, ex); end
  endtask

  task automatic test_direction();
    scanCode_E0 = 8'h75; #1;
    checks++; if (direction_flag !== 1'b0) begin errors++;
      $display("FAIL dir_not_comb actual=%0b required=0", direction_flag); end
    check_dir(8'h75, 1'b1);
    check_dir(8'h5A, 1'b0);
    check_dir(8'h72, 1'b1);
    check_dir(8'h6B, 1'b1);
    check_dir(8'h74, 1'b1);
    check_dir(8'h73, 1'b0);
  endtask

  task automatic test_async_reset();
    h_addr = 10'd20; color_text = 24'hFFFFFF; color_background = 24'h808080;
    line = 12'h004; scanCode_E0 = 8'h74;
    @(posedge clk); #3;
    checks++; if (showcolor !== 24'hFFFFFF || direction_flag !== 1'b1) begin errors++;
      $display("FAIL pre_reset actual=%06h/%0b required=FFFFFF/1", showcolor, direction_flag); end
    rst_n = 1'b0; #1;
    checks++; if (direction_flag !== 1'b0) begin errors++;
      $display("FAIL async_dir actual=%0b required=0", direction_flag); end
    checks++; if (showcolor !== 24'h0) begin errors++;
      $display("FAIL async_showcolor actual=%06h required=000000", showcolor); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (showcolor !== 24'hFFFFFF || direction_flag !== 1'b1) begin errors++;
      $display("FAIL post_reset actual=%06h/%0b required=FFFFFF/1", showcolor, direction_flag); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_address();
    test_color();
    test_margin();
    test_header();
    test_direction();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_memory_assign.md
VIDEO_MEMORY_ASSIGN -- requirements
Module: video_memory_assign

Interface
REQ-001 Parameter BASH_HEAD_LEN, default 9: number of prompt-header character cells at the start of a prompt line.
REQ-002 Parameter HEAD_STR, default "MYS@bash$": 9-character prompt string. Byte 0 is the leftmost character.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 h_addr, v_addr  in  10 each  VGA pixel coordinates.
REQ-006 roll_cnt  in  13  scroll offset, in characters.
REQ-007 char_code  in  8  ASCII code currently stored at keys_index.
REQ-008 line, line_header  in  12 each  font-ROM rows returned one cycle after vm_index / vm_index_header.
REQ-009 scanCode_E0  in  8  extended scan code.
REQ-010 color_background, color_text  in  24 each  active colour scheme.
REQ-011 keysX, keysY  out  8 each  character column and row.
REQ-012 keys_index  out  13  character-memory address.
REQ-013 offsetX, offsetY  out  8 each  pixel offset inside the character cell.
REQ-014 vm_index, vm_index_header  out  12 each  font-ROM row addresses.
REQ-015 showcolor, showcolor_header  out  24 each  pixel colours.
REQ-016 direction_flag  out  1  registered arrow-key indication.

Function
REQ-017 Character cells SHALL be 9x16 pixels. keysX = h_addr/9; keysY = v_addr/16, both combinational.
REQ-018 offsetX = h_addr - 9*keysX (range 0..8); offsetY = v_addr - 16*keysY (range 0..15), both combinational.
REQ-019 keys_index = keysY*70 + keysX + roll_cnt, combinational, truncated modulo 2^13.
REQ-020 vm_index = char_code*16 + offsetY, combinational, truncated to 12 bits.
REQ-021 vm_index_header = HEAD_STR[keysX]*16 + offsetY when keysX < BASH_HEAD_LEN, else 0.
REQ-022 Stage-2 registers SHALL capture offsetX, h_addr>=630, color_background and color_text every clock, so they align with the one-cycle font-ROM latency.
REQ-023 showcolor SHALL be combinational from the stage-2 registers: delayed colour_text if line[offsetX_d] = 1, else delayed colour_background. Bit 0 of line is the leftmost pixel.
REQ-024 showcolor_header SHALL follow the same rule using line_header.
REQ-025 If the delayed h_addr was >= 630 (right margin), showcolor and showcolor_header SHALL both equal the delayed background.
REQ-026 direction_flag SHALL be registered: 1 on the clock after scanCode_E0 is 0x75, 0x72, 0x6B or 0x74; 0 otherwise.
REQ-027 Addresses SHALL still be computed when h_addr >= 630 or v_addr >= 480; no clamping is applied.

Reset
REQ-028 While rst_n = 0, asynchronously clear all stage-2 registers and direction_flag to 0. showcolor and showcolor_header therefore read 0.
REQ-029 On the first rising clk edge after rst_n rises, normal capture resumes with no further latency.

Configuration
REQ-030 Macro VMA_HEADER_EN, when defined, includes the header path (REQ-021, REQ-024).
REQ-031 Without VMA_HEADER_EN: vm_index_header = vm_index, showcolor_header = showcolor, and line_header is ignored.

Verification
REQ-032 h_addr=20, v_addr=35, roll_cnt=0 -> keysX=2, keysY=2, offsetX=2, offsetY=3, keys_index=142.
REQ-033 Same pixel with roll_cnt=70, char_code=0x41 -> keys_index=212, vm_index=0x413.
REQ-034 line=12'h004, offsetX=2, text=FFFFFF, background=000000 -> showcolor=FFFFFF one clock later; with line=0 -> 000000.
REQ-035 h_addr=635 with line all ones -> showcolor equals background one clock later.
REQ-036 scanCode_E0 = 0x75, then 0x5A -> direction_flag is 1, then 0 on the following clocks.
REQ-037 Drive rst_n low mid-frame -> direction_flag and showcolor read 0 immediately, without waiting for a clock edge.
